hazard_ctrl: RTL and testbench

//  Decode-stage hazard/forwarding controller for the 5-stage MIPS pipeline. Consumes per-instruction
//  T_use/T_new and resolved GRF write address from the D-stage control unit. Keeps its own E/M/W

---
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard and forwarding controller with a private E/M/W scoreboard.
// Optional HAZ_STALL_CNT_EN adds a 32-bit count of stalled cycles on port stall_cnt.
module hazard_ctrl #(
  parameter int unsigned RA_W = 5,
  parameter int unsigned T_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] rs_D,
  input  logic [RA_W-1:0] rt_D,
  input  logic [RA_W-1:0] waddr_D,
  input  logic [T_W-1:0]  t_use_rs_D,
  input  logic [T_W-1:0]  t_use_rt_D,
  input  logic [T_W-1:0]  t_new_D,
  output logic            stall_D,
  output logic            flush_E,
  output logic [1:0]      fwd_rs_D,
  output logic [1:0]      fwd_rt_D,
  output logic [1:0]      fwd_rs_E,
  output logic [1:0]      fwd_rt_E,
  output logic            fwd_rt_M
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam logic [T_W-1:0] TUnused = '1;

  logic [RA_W-1:0] e_rs_q, e_rt_q, e_waddr_q;
  logic [T_W-1:0]  e_tnew_q;
  logic [RA_W-1:0] m_rt_q, m_waddr_q;
  logic [T_W-1:0]  m_tnew_q;
  logic [RA_W-1:0] w_waddr_q;
  logic            rs_hit, rt_hit;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x != '0) ? x - T_W'(1) : '0;
  endfunction

  // A reader must wait if a pending producer's result arrives later than it is needed.
  function automatic logic stall_hit(input logic [RA_W-1:0] r, input logic [T_W-1:0] tu,
                                     input logic [RA_W-1:0] ew, input logic [T_W-1:0] et,
                                     input logic [RA_W-1:0] mw, input logic [T_W-1:0] mt);
    return (r != '0) && (tu != TUnused) &&
           (((r == ew) && (tu < et)) || ((r == mw) && (tu < mt)));
  endfunction

  function automatic logic [1:0] fwd_d(input logic [RA_W-1:0] r,
                                       input logic [RA_W-1:0] ew, input logic [T_W-1:0] et,
                                       input logic [RA_W-1:0] mw, input logic [T_W-1:0] mt);
    if ((r != '0) && (r == ew) && (et == '0)) return 2'b01;
    if ((r != '0) && (r == mw) && (mt == '0)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] r,
                                       input logic [RA_W-1:0] mw, input logic [T_W-1:0] mt,
                                       input logic [RA_W-1:0] ww);
    if ((r != '0) && (r == mw) && (mt == '0)) return 2'b01;
    if ((r != '0) && (r == ww)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    rs_hit   = stall_hit(rs_D, t_use_rs_D, e_waddr_q, e_tnew_q, m_waddr_q, m_tnew_q);
    rt_hit   = stall_hit(rt_D, t_use_rt_D, e_waddr_q, e_tnew_q, m_waddr_q, m_tnew_q);
    stall_D  = rs_hit | rt_hit;
    flush_E  = stall_D;
    fwd_rs_D = fwd_d(rs_D, e_waddr_q, e_tnew_q, m_waddr_q, m_tnew_q);
    fwd_rt_D = fwd_d(rt_D, e_waddr_q, e_tnew_q, m_waddr_q, m_tnew_q);
    fwd_rs_E = fwd_e(e_rs_q, m_waddr_q, m_tnew_q, w_waddr_q);
    fwd_rt_E = fwd_e(e_rt_q, m_waddr_q, m_tnew_q, w_waddr_q);
    fwd_rt_M = (m_rt_q != '0) && (m_rt_q == w_waddr_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_rs_q    <= '0;
      e_rt_q    <= '0;
      e_waddr_q <= '0;
      e_tnew_q  <= '0;
      m_rt_q    <= '0;
      m_waddr_q <= '0;
      m_tnew_q  <= '0;
      w_waddr_q <= '0;
    end else begin
      // A stall injects an all-zero bubble into E; M and W never hold.
      if (stall_D) begin
        e_rs_q    <= '0;
        e_rt_q    <= '0;
        e_waddr_q <= '0;
        e_tnew_q  <= '0;
      end else begin
        e_rs_q    <= rs_D;
        e_rt_q    <= rt_D;
        e_waddr_q <= waddr_D;
        e_tnew_q  <= sat_dec(t_new_D);
      end
      m_rt_q    <= e_rt_q;
      m_waddr_q <= e_waddr_q;
      m_tnew_q  <= sat_dec(e_tnew_q);
      w_waddr_q <= m_waddr_q;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall_D) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl: each row is driven, its expectation queued, then
// popped and compared while the row is still presented.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, waddr_D;
  logic [1:0] t_use_rs_D, t_use_rt_D, t_new_D;
  logic       stall_D, flush_E;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic       fwd_rt_M;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .waddr_D    (waddr_D),
    .t_use_rs_D (t_use_rs_D),
    .t_use_rt_D (t_use_rt_D),
    .t_new_D    (t_new_D),
    .stall_D    (stall_D),
    .flush_E    (flush_E),
    .fwd_rs_D   (fwd_rs_D),
    .fwd_rt_D   (fwd_rt_D),
    .fwd_rs_E   (fwd_rs_E),
    .fwd_rt_E   (fwd_rt_E),
    .fwd_rt_M   (fwd_rt_M)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic       rstn;
    logic [4:0] rs, rt, wa;
    logic [1:0] tur, tut, tn;
    logic       st;
    logic [1:0] frsd, frtd, frse, frte;
    logic       frtm;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          row      = 0;
  logic [31:0] exp_cnt  = 32'd0;

  function automatic vec_t mk(input logic rstn, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] wa, input logic [1:0] tur,
                              input logic [1:0] tut, input logic [1:0] tn, input logic st,
                              input logic [1:0] frsd, input logic [1:0] frtd,
                              input logic [1:0] frse, input logic [1:0] frte, input logic frtm);
    vec_t v;
    v.rstn = rstn; v.rs = rs; v.rt = rt; v.wa = wa;
    v.tur = tur; v.tut = tut; v.tn = tn;
    v.st = st; v.frsd = frsd; v.frtd = frtd; v.frse = frse; v.frte = frte; v.frtm = frtm;
    return v;
  endfunction

  function automatic vec_t nop(input logic [1:0] frse, input logic [1:0] frte,
                               input logic frtm);
    return mk(1'b1, 5'd0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0, frse, frte, frtm);
  endfunction

  task automatic cmp(input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL row=%0d %s got=%0h exp=%0h", row, what, got, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    e = exp_q.pop_front();
    cmp("stall_D",  32'(stall_D),  32'(e.st));
    cmp("flush_E",  32'(flush_E),  32'(e.st));
    cmp("fwd_rs_D", 32'(fwd_rs_D), 32'(e.frsd));
    cmp("fwd_rt_D", 32'(fwd_rt_D), 32'(e.frtd));
    cmp("fwd_rs_E", 32'(fwd_rs_E), 32'(e.frse));
    cmp("fwd_rt_E", 32'(fwd_rt_E), 32'(e.frte));
    cmp("fwd_rt_M", 32'(fwd_rt_M), 32'(e.frtm));
`ifdef HAZ_STALL_CNT_EN
    cmp("stall_cnt", stall_cnt, exp_cnt);
`endif
    // Counter value expected after the coming edge.
    exp_cnt = !e.rstn ? 32'd0 : (e.st ? exp_cnt + 32'd1 : exp_cnt);
    row++;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset      = v.rstn;
    rs_D       = v.rs;
    rt_D       = v.rt;
    waddr_D    = v.wa;
    t_use_rs_D = v.tur;
    t_use_rt_D = v.tut;
    t_new_D    = v.tn;
    exp_q.push_back(v);
    #2;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; rs_D = '0; rt_D = '0; waddr_D = '0;
    t_use_rs_D = 2'd3; t_use_rt_D = 2'd3; t_new_D = '0;
    repeat (2) @(posedge clk);

    // rstn rs rt wa tur tut tn | st frsd frtd frse frte frtm
    vecs.push_back(nop(0, 0, 0));                                   // reset state
    // lw $8 then add $9,$8,$8
    vecs.push_back(mk(1, 29, 8, 8, 1, 3, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  8, 8, 9, 1, 1, 2, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  8, 8, 9, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(2, 2, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // add $1 then beq $1,$2
    vecs.push_back(mk(1, 3, 4, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(nop(2, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // jal then jr $31
    vecs.push_back(mk(1,  0, 0, 31, 3, 3, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 31, 0,  0, 0, 3, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(nop(1, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // lw $5 then sw $5
    vecs.push_back(mk(1, 6, 5, 5, 1, 3, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 5, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 1));
    vecs.push_back(nop(0, 0, 0));
    // $0 never matches
    vecs.push_back(mk(1, 0, 0, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // two writers of $3: youngest wins
    vecs.push_back(mk(1, 0, 0, 3, 3, 3, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3, 3, 3, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(nop(1, 1, 0));
    vecs.push_back(nop(0, 0, 1));
    vecs.push_back(nop(0, 0, 0));
    // t_use = 3 means unused: no stall
    vecs.push_back(mk(1, 0, 0, 6, 3, 3, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6, 6, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 1));
    vecs.push_back(nop(0, 0, 0));
    // reset while stalled
    vecs.push_back(mk(1, 29, 4, 4, 1, 3, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,  4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // lw $4 then beq $4: two-cycle stall, then add $1/beq $1: one more stall.
    apply(mk(1, 29, 4, 4, 1, 3, 3, 0, 0, 0, 0, 0, 0));
    apply(mk(1,  4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    apply(mk(1,  4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    apply(mk(1,  4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1,  2, 3, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    apply(mk(1,  1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    apply(mk(0,  1, 2, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
`ifdef HAZ_STALL_CNT_EN
    cmp("stall_cnt_three", stall_cnt, 32'd3);
`endif
    apply(nop(0, 0, 0));
`ifdef HAZ_STALL_CNT_EN
    cmp("stall_cnt_cleared", stall_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
